// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the counter control front end: debounce state
// encoding and synchroniser depth.
package cnt_ctrl_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_WT = 2'd1,
    HELD     = 2'd2,
    REL_WT   = 2'd3
  } deb_state_t;

endpackage

// File: rtl/cnt_ctrl_front_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a press/release
// debounce FSM that emits exactly one o_press per accepted press.
module btn_debounce
  import cnt_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   btn_s;
  deb_state_t             state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= i_btn;
        end
      end else begin : g_rest
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign btn_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A level change during either wait state aborts the wait immediately.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WT;
          cnt_next   = '0;
        end
      end
      PRESS_WT: begin
        if (!btn_s)                state_next = IDLE;
        else if (cnt_reg == CNT_MAX) state_next = HELD;
        else                       cnt_next   = cnt_reg + CW'(1);
      end
      HELD: begin
        if (!btn_s) begin
          state_next = REL_WT;
          cnt_next   = '0;
        end
      end
      REL_WT: begin
        if (btn_s)                 state_next = HELD;
        else if (cnt_reg == CNT_MAX) state_next = IDLE;
        else                       cnt_next   = cnt_reg + CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_press = (state_reg == PRESS_WT) && btn_s && (cnt_reg == CNT_MAX);
  end

endmodule

// File: rtl/cnt_ctrl_front.sv
// Control front end for the 4-bit up/down counter: direction toggle, reload
// pulse and tick prescaler. Optional pause button with CNT_CTRL_PAUSE_EN.
module cnt_ctrl_front
  import cnt_ctrl_pkg::*;
#(
  parameter int DIV        = 16,
  parameter int DEB_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_dir,
`ifdef CNT_CTRL_PAUSE_EN
  input  logic i_btn_pause,
  output logic o_pause,
`endif
  output logic o_tick,
  output logic o_mode,
  output logic o_cnt_rst
);

`ifdef CNT_CTRL_PAUSE_EN
  localparam int NUM_BTN = 2;
`else
  localparam int NUM_BTN = 1;
`endif
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  logic [PW-1:0]      pre_cnt_reg;
  logic               tick_reg;
  logic               mode_reg;
  logic               cnt_rst_reg;
  logic               paused;

  assign btn_raw[0] = i_btn_dir;
`ifdef CNT_CTRL_PAUSE_EN
  assign btn_raw[1] = i_btn_pause;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_deb
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (btn_raw[gi]),
        .o_press(press[gi])
      );
    end
  endgenerate

`ifdef CNT_CTRL_PAUSE_EN
  logic pause_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         pause_reg <= 1'b0;
    else if (press[1]) pause_reg <= ~pause_reg;
  end

  assign paused  = pause_reg;
  assign o_pause = pause_reg;
`else
  assign paused = 1'b0;
`endif

  // A direction press outranks a due tick so the counter reloads cleanly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_cnt_reg <= '0;
      tick_reg    <= 1'b0;
      mode_reg    <= 1'b0;
      cnt_rst_reg <= 1'b0;
    end else begin
      cnt_rst_reg <= press[0];
      if (press[0]) begin
        mode_reg    <= ~mode_reg;
        pre_cnt_reg <= '0;
        tick_reg    <= 1'b0;
      end else if (paused) begin
        tick_reg    <= 1'b0;
      end else begin
        tick_reg    <= (pre_cnt_reg == PRE_MAX);
        pre_cnt_reg <= (pre_cnt_reg == PRE_MAX) ? '0 : pre_cnt_reg + PW'(1);
      end
    end
  end

  assign o_tick    = tick_reg;
  assign o_mode    = mode_reg;
  assign o_cnt_rst = cnt_rst_reg;

endmodule

// File: tb/tb_cnt_ctrl_front.sv
// Scoreboard bench for cnt_ctrl_front (DIV=4, DEB_CYCLES=3); the reference
// model tracks run lengths of the synchronised button level.
module tb_cnt_ctrl_front;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic i_clk     = 1'b0;
  logic i_rst     = 1'b1;
  logic i_btn_dir = 1'b0;
  logic o_tick, o_mode, o_cnt_rst;
`ifdef CNT_CTRL_PAUSE_EN
  logic i_btn_pause = 1'b0;
  logic o_pause;
`endif

  cnt_ctrl_front #(
    .DIV       (DIV),
    .DEB_CYCLES(DEB)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_btn_dir  (i_btn_dir),
`ifdef CNT_CTRL_PAUSE_EN
    .i_btn_pause(i_btn_pause),
    .o_pause    (o_pause),
`endif
    .o_tick     (o_tick),
    .o_mode     (o_mode),
    .o_cnt_rst  (o_cnt_rst)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic tick;
    logic mode;
    logic cnt_rst;
    logic pause;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  bit m_s1[2], m_s2[2], m_armed[2];
  int m_ones[2], m_zeros[2];
  bit m_mode, m_cnt_rst, m_tick, m_pause;
  int m_phase;
  bit cur_rst = 1'b1, cur_dir = 1'b0, cur_pause = 1'b0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_ones[k] = 0; m_zeros[k] = 0; m_armed[k] = 1;
    end
    m_mode = 0; m_cnt_rst = 0; m_tick = 0; m_pause = 0; m_phase = 0;
  endfunction

  // Press accepted after DEB+1 consecutive high samples while armed; re-armed
  // after DEB+1 consecutive low samples.
  function automatic bit deb_step(int k, bit raw);
    bit bs, ev;
    bs = m_s2[k];
    m_s2[k] = m_s1[k];
    m_s1[k] = raw;
    if (bs) begin m_ones[k]++; m_zeros[k] = 0; end
    else    begin m_zeros[k]++; m_ones[k] = 0; end
    ev = 0;
    if (m_armed[k] && m_ones[k] == DEB + 1) begin
      ev = 1; m_armed[k] = 0;
    end else if (!m_armed[k] && m_zeros[k] == DEB + 1) begin
      m_armed[k] = 1;
    end
    return ev;
  endfunction

  function automatic void model_step(bit dir, bit pau);
    bit ev_d, ev_p, held;
    ev_d = deb_step(0, dir);
    ev_p = deb_step(1, pau);
`ifdef CNT_CTRL_PAUSE_EN
    held = m_pause;
`else
    held = 1'b0;
`endif
    if (ev_d) begin
      m_mode = !m_mode; m_cnt_rst = 1; m_tick = 0; m_phase = 0;
    end else if (held) begin
      m_cnt_rst = 0; m_tick = 0;
    end else begin
      m_cnt_rst = 0;
      m_tick    = (m_phase == DIV - 1);
      m_phase   = (m_phase + 1) % DIV;
    end
    if (ev_p) m_pause = !m_pause;
  endfunction

  task automatic cyc(input bit rst, input bit dir, input bit pau);
    exp_t e;
    @(posedge i_clk);
    #1;
    if (!cur_rst) model_step(cur_dir, cur_pause);
    cur_rst = rst; cur_dir = dir; cur_pause = pau;
    i_rst     = rst;
    i_btn_dir = dir;
`ifdef CNT_CTRL_PAUSE_EN
    i_btn_pause = pau;
`endif
    if (rst) model_reset();
    e.tick = m_tick; e.mode = m_mode; e.cnt_rst = m_cnt_rst; e.pause = m_pause;
    sb_q.push_back(e);
  endtask

  function automatic void check_bit(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_bit("tick", o_tick, e.tick);
        check_bit("mode", o_mode, e.mode);
        check_bit("cnt_rst", o_cnt_rst, e.cnt_rst);
`ifdef CNT_CTRL_PAUSE_EN
        check_bit("pause", o_pause, e.pause);
`endif
        check_bit("tick_rst_excl", o_tick & o_cnt_rst, 1'b0);
      end
    end
  end

  initial begin : stim
    bit d, p;
    model_reset();
    repeat (3) cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    // bounce, then a clean hold
    cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
    repeat (10) cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 0);
    // presses landing at every prescaler phase
    for (int off = 0; off < DIV; off++) begin
      repeat (off) cyc(0, 0, 0);
      repeat (8) cyc(0, 1, 0);
      repeat (8) cyc(0, 0, 0);
    end
    // long hold, release, press again
    repeat (20) cyc(0, 1, 0);
    repeat (8) cyc(0, 0, 0);
    repeat (8) cyc(0, 1, 0);
    repeat (8) cyc(0, 0, 0);
    // reset while waiting out a press, button kept down through release
    repeat (4) cyc(0, 1, 0);
    repeat (2) cyc(1, 1, 0);
    repeat (12) cyc(0, 1, 0);
    repeat (8) cyc(0, 0, 0);
    // pause, direction press while paused, un-pause
    repeat (8) cyc(0, 0, 1);
    repeat (8) cyc(0, 0, 0);
    repeat (8) cyc(0, 1, 0);
    repeat (8) cyc(0, 0, 0);
    repeat (8) cyc(0, 0, 1);
    repeat (12) cyc(0, 0, 0);
    d = 0; p = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) d = !d;
      if ($urandom_range(0, 6) == 0) p = !p;
      cyc(($urandom_range(0, 399) == 0), d, p);
    end
    repeat (3) cyc(0, 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
